// File: rtl/lfsr_rand_gen_pkg.sv
// lfsr_rand_gen_pkg: shared LFSR taps, default seed, FSM encoding and helpers
package lfsr_rand_gen_pkg;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
  // limit 0 wraps to x=0xFF, giving the full-range mask
  function automatic logic [7:0] smear_mask(input logic [7:0] lim);
    logic [7:0] x;
    x = lim - 8'd1;
    return x | (x >> 1) | (x >> 2) | (x >> 4);
  endfunction
endpackage

// File: rtl/tick_edge_sync.sv
// tick_edge_sync: two-flop synchronizer plus rising-edge detector
module tick_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);
  logic sync1_q, sync2_q, prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  assign rise_pulse = sync2_q & ~prev_q;
endmodule

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: tick-driven 16-bit LFSR with rejection-sampled bounded random numbers
module lfsr_rand_gen
  import lfsr_rand_gen_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lfsr_tick_src,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        req,
  input  logic [7:0]  limit,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  rand_out,
  output logic [15:0] lfsr_state
);
  logic step, take;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [7:0] limit_q, limit_d, rand_q, rand_d, cand;
  logic busy_q, busy_d, valid_q, valid_d;
  state_e state_q, state_d;
  tick_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (lfsr_tick_src),
    .rise_pulse (step)
  );
  // a seed load swallows a coincident step, so it can never produce an acceptance
  always_comb begin
    lfsr_nx = lfsr_next(lfsr_q);
    cand    = lfsr_nx[7:0] & smear_mask(limit_q);
    take    = step && !seed_load && (limit_q == 8'd0 || cand < limit_q);
    lfsr_d  = seed_load ? (seed == 16'd0 ? DEFAULT_SEED : seed) : step ? lfsr_nx : lfsr_q;
    state_d = state_q;
    limit_d = limit_q;
    rand_d  = rand_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        state_d = WAIT;
        limit_d = limit;
        busy_d  = 1'b1;
      end
      WAIT: if (take) begin
        state_d = DONE;
        rand_d  = cand;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr_q  <= DEFAULT_SEED;
      state_q <= IDLE;
      limit_q <= 8'd0;
      rand_q  <= 8'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      limit_q <= limit_d;
      rand_q  <= rand_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign rand_out   = rand_q;
  assign lfsr_state = lfsr_q;
endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen: table-driven, directed and randomized checks against a reference model
module tb_lfsr_rand_gen;
  logic clk = 1'b0, rst = 1'b1, lfsr_tick_src = 1'b0, seed_load = 1'b0, req = 1'b0;
  logic [15:0] seed = 16'd0;
  logic [7:0] limit = 8'd0;
  logic busy, valid;
  logic [7:0] rand_out, last_rand = 8'd0;
  logic [15:0] lfsr_state, prev_lfsr = 16'd0;
  int total = 0, bad = 0, vcount = 0, steps_seen = 0;

  typedef struct { int lim; int n; logic [7:0] exp; } vec_t;
  vec_t vt[6];
  logic [15:0] lfsr_tab[4];

  always #5 clk = ~clk;

  lfsr_rand_gen dut (
    .clk           (clk),
    .rst           (rst),
    .lfsr_tick_src (lfsr_tick_src),
    .seed_load     (seed_load),
    .seed          (seed),
    .req           (req),
    .limit         (limit),
    .busy          (busy),
    .valid         (valid),
    .rand_out      (rand_out),
    .lfsr_state    (lfsr_state)
  );

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      last_rand = rand_out;
    end
    if (lfsr_state !== prev_lfsr) steps_seen++;
    prev_lfsr = lfsr_state;
  end

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    int taps[4] = '{16, 14, 13, 11};
    int fb = 0;
    foreach (taps[i]) fb ^= int'(s[taps[i]-1]);
    return 16'((int'(s) * 2 + fb) % 65536);
  endfunction

  function automatic logic [7:0] ref_mask(input int lim);
    int x = (lim + 255) % 256;
    return 8'(x | (x / 2) | (x / 4) | (x / 16));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; lfsr_tick_src = 1'b0; seed_load = 1'b0; req = 1'b0; seed = 16'd0; limit = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_n(input int h);
    @(posedge clk);
    #1 lfsr_tick_src = 1'b1;
    repeat (h) @(posedge clk);
    #1 lfsr_tick_src = 1'b0;
    repeat (h) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue_req(input int l);
    @(posedge clk);
    #1 req = 1'b1; limit = 8'(l);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
  endtask

  int v0, s0, ticks, done_reqs, lim;
  logic pending, ok;
  logic [15:0] m;
  logic [7:0] cand;

  initial begin
    vt[0] = '{0, 1, 8'hC3};
    vt[1] = '{3, 4, 8'h02};
    vt[2] = '{1, 1, 8'h00};
    vt[3] = '{10, 1, 8'h03};
    vt[4] = '{128, 1, 8'h43};
    vt[5] = '{255, 1, 8'hC3};
    lfsr_tab = '{16'h59C3, 16'hB387, 16'h670F, 16'hCE1E};

    do_reset();
    chk("rst_lfsr", lfsr_state, 16'hACE1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rand", rand_out, 0);
    for (int i = 0; i < 4; i++) begin
      tick_n(5);
      chk($sformatf("lfsr_tick%0d", i + 1), lfsr_state, lfsr_tab[i]);
    end

    for (int i = 0; i < 6; i++) begin
      do_reset();
      v0 = vcount;
      issue_req(vt[i].lim);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      for (int t = 1; t <= vt[i].n; t++) begin
        tick_n(5);
        if (t < vt[i].n) chk($sformatf("vec%0d_wait%0d", i, t), {busy, 8'(vcount - v0)}, {1'b1, 8'd0});
      end
      chk($sformatf("vec%0d_valid", i), vcount - v0, 1);
      chk($sformatf("vec%0d_rand", i), last_rand, vt[i].exp);
      chk($sformatf("vec%0d_idle", i), {busy, rand_out}, {1'b0, vt[i].exp});
    end

    do_reset();
    v0 = vcount;
    issue_req(3);
    issue_req(0);
    repeat (4) tick_n(5);
    chk("req_ignored_cnt", vcount - v0, 1);
    chk("req_ignored_rand", last_rand, 2);

    do_reset();
    tick_n(5);
    @(posedge clk);
    #1 lfsr_tick_src = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 seed_load = 1'b1; seed = 16'd0;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    chk("seed0_coincide", lfsr_state, 16'hACE1);
    repeat (5) @(posedge clk);
    #1 lfsr_tick_src = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("seed0_dropped", lfsr_state, 16'hACE1);
    tick_n(5);
    chk("seed0_next", lfsr_state, 16'h59C3);
    @(posedge clk);
    #1 seed_load = 1'b1; seed = 16'h1234;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    chk("seed_load", lfsr_state, 16'h1234);
    tick_n(5);
    chk("seed_step", lfsr_state, ref_next(16'h1234));

    do_reset();
    v0 = vcount;
    issue_req(3);
    tick_n(5);
    @(posedge clk);
    #1 seed_load = 1'b1; seed = 16'd0;
    @(posedge clk);
    #1 seed_load = 1'b0;
    @(negedge clk);
    chk("wait_reseed_busy", {busy, lfsr_state}, {1'b1, 16'hACE1});
    repeat (4) tick_n(5);
    chk("wait_reseed_cnt", vcount - v0, 1);
    chk("wait_reseed_rand", last_rand, 2);

    do_reset();
    v0 = vcount;
    issue_req(10);
    #3 rst = 1'b1;
    #10 rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_busy", busy, 0);
    tick_n(5);
    chk("rst_wait_lfsr", lfsr_state, 16'h59C3);
    chk("rst_wait_novalid", vcount - v0, 0);

    do_reset();
    v0 = vcount;
    issue_req(5);
    repeat (60) @(negedge clk);
    chk("no_tick_state", {busy, rand_out, lfsr_state}, {1'b1, 8'd0, 16'hACE1});
    chk("no_tick_novalid", vcount - v0, 0);

    rst = 1'b1;
    lfsr_tick_src = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("high_at_release", lfsr_state, 16'h59C3);
    repeat (20) @(negedge clk);
    chk("high_single_step", lfsr_state, 16'h59C3);
    lfsr_tick_src = 1'b0;

    do_reset();
    s0 = steps_seen; m = 16'hACE1; pending = 1'b0; ticks = 0; done_reqs = 0; lim = 0;
    while (done_reqs < 250 && ticks < 900) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        lim = int'($urandom_range(0, 255));
        issue_req(lim);
        pending = 1'b1;
      end
      v0 = vcount;
      tick_n(48);
      ticks++;
      m = ref_next(m);
      cand = m[7:0] & ref_mask(lim);
      ok = pending && (lim == 0 || int'(cand) < lim);
      chk("rnd_lfsr", lfsr_state, m);
      chk("rnd_valid", vcount - v0, ok ? 1 : 0);
      if (ok) begin
        chk("rnd_rand", last_rand, cand);
        if (lim != 0) chk("rnd_bound", int'(last_rand) < lim, 1);
        pending = 1'b0;
        done_reqs++;
      end
      chk("rnd_busy", busy, pending);
    end
    chk("rnd_steps", steps_seen - s0, ticks);
    chk("rnd_reqs_done", done_reqs >= 250, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
